// File: rtl/seven_segment_fsm_if.sv
// Operand-entry and display bus of the binary16 multiplier.
// The board side (switches, button and digits) is the master; the design is the slave.
interface seven_segment_fsm_if;
  logic [15:0] na;
  logic        SAVE;
  logic [6:0]  LED_out;
  logic        d0;
  logic        d1;
  logic        d2;
  logic        d3;

  modport master (
    output na,
    output SAVE,
    input  LED_out,
    input  d0,
    input  d1,
    input  d2,
    input  d3
  );

  modport slave (
    input  na,
    input  SAVE,
    output LED_out,
    output d0,
    output d1,
    output d2,
    output d3
  );
endinterface

// File: rtl/seven_segment_fsm.sv
// Binary16 multiplier with a three-state operand-entry FSM and a multiplexed
// 4-digit common-anode hex display (live operand while loading, product in SHOW).
module seven_segment_fsm #(
  parameter int REFRESH_BITS = 18
) (
  input logic           clk,
  input logic           rst,
  seven_segment_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SHOW   = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [15:0]             a_reg;
  logic [15:0]             a_next;
  logic [15:0]             b_reg;
  logic [15:0]             b_next;
  logic                    save_q_reg;
  logic [REFRESH_BITS-1:0] refresh_reg;
  logic                    save_evt;

  assign save_evt = bus.SAVE & ~save_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= LOAD_A;
      a_reg       <= 16'h0000;
      b_reg       <= 16'h0000;
      save_q_reg  <= 1'b0;
      refresh_reg <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      save_q_reg  <= bus.SAVE;
      refresh_reg <= refresh_reg + REFRESH_BITS'(1);
    end
  end

  // A capture from SHOW starts the next calculation directly, skipping LOAD_A.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state_reg)
      LOAD_A: begin
        if (save_evt) begin
          a_next     = bus.na;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (save_evt) begin
          b_next     = bus.na;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (save_evt) begin
          a_next     = bus.na;
          state_next = LOAD_B;
        end
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

  // Multiplier datapath
  logic              sign_a;
  logic              sign_b;
  logic [4:0]        exp_a;
  logic [4:0]        exp_b;
  logic [9:0]        frac_a;
  logic [9:0]        frac_b;
  logic              nan_a;
  logic              nan_b;
  logic              inf_a;
  logic              inf_b;
  logic              zero_a;
  logic              zero_b;
  logic              sign_p;
  logic [21:0]       sig_prod;
  logic              norm_shift;
  logic signed [7:0] exp_sum;
  logic [9:0]        frac_p;
  logic [15:0]       product;
  logic              unused_frac_bits;

  assign sign_a = a_reg[15];
  assign sign_b = b_reg[15];
  assign exp_a  = a_reg[14:10];
  assign exp_b  = b_reg[14:10];
  assign frac_a = a_reg[9:0];
  assign frac_b = b_reg[9:0];

  assign nan_a  = (exp_a == 5'h1F) && (frac_a != 10'h000);
  assign nan_b  = (exp_b == 5'h1F) && (frac_b != 10'h000);
  assign inf_a  = (exp_a == 5'h1F) && (frac_a == 10'h000);
  assign inf_b  = (exp_b == 5'h1F) && (frac_b == 10'h000);
  // Subnormals are flushed: any zero exponent field counts as zero.
  assign zero_a = (exp_a == 5'h00);
  assign zero_b = (exp_b == 5'h00);

  assign sign_p     = sign_a ^ sign_b;
  assign sig_prod   = {11'h000, 1'b1, frac_a} * {11'h000, 1'b1, frac_b};
  assign norm_shift = sig_prod[21];
  assign exp_sum    = signed'({3'b000, exp_a}) + signed'({3'b000, exp_b})
                    - 8'sd15 + signed'({7'b0000000, norm_shift});
  // Truncation: bits below the kept fraction are simply dropped.
  assign frac_p     = norm_shift ? sig_prod[20:11] : sig_prod[19:10];
  assign unused_frac_bits = ^sig_prod[9:0];

  always_comb begin
    product = 16'h0000;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      product = 16'h7E00;
    end else if (inf_a || inf_b) begin
      product = {sign_p, 15'h7C00};
    end else if (zero_a || zero_b) begin
      product = {sign_p, 15'h0000};
    end else if (exp_sum >= 8'sd31) begin
      product = {sign_p, 15'h7C00};
    end else if (exp_sum <= 8'sd0) begin
      product = {sign_p, 15'h0000};
    end else begin
      product = {sign_p, exp_sum[4:0], frac_p};
    end
  end

  // Display multiplexing
  logic [15:0] disp_value;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic [3:0]  digit_n;

  assign disp_value = (state_reg == SHOW) ? product : bus.na;
  assign sel        = refresh_reg[REFRESH_BITS-1 -: 2];
  assign nibble     = disp_value[{sel, 2'b00} +: 4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_n[gi] = (sel != 2'(gi));
    end
  endgenerate

  assign bus.d0 = digit_n[0];
  assign bus.d1 = digit_n[1];
  assign bus.d2 = digit_n[2];
  assign bus.d3 = digit_n[3];

  always_comb begin
    bus.LED_out = 7'b1111111;
    case (nibble)
      4'h0: bus.LED_out = 7'b0000001;
      4'h1: bus.LED_out = 7'b1001111;
      4'h2: bus.LED_out = 7'b0010010;
      4'h3: bus.LED_out = 7'b0000110;
      4'h4: bus.LED_out = 7'b1001100;
      4'h5: bus.LED_out = 7'b0100100;
      4'h6: bus.LED_out = 7'b0100000;
      4'h7: bus.LED_out = 7'b0001111;
      4'h8: bus.LED_out = 7'b0000000;
      4'h9: bus.LED_out = 7'b0000100;
      4'hA: bus.LED_out = 7'b0001000;
      4'hB: bus.LED_out = 7'b1100000;
      4'hC: bus.LED_out = 7'b0110001;
      4'hD: bus.LED_out = 7'b1000010;
      4'hE: bus.LED_out = 7'b0110000;
      4'hF: bus.LED_out = 7'b0111000;
      default: bus.LED_out = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_seven_segment_fsm.sv
// Directed bench for seven_segment_fsm: operand entry, binary16 products and the
// multiplexed display, with every expected value worked out by hand.
module tb_seven_segment_fsm;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seven_segment_fsm_if bus ();

  seven_segment_fsm #(.REFRESH_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Four consecutive negedge samples cover every digit once (refresh counter is 2 bits).
  task automatic check_display(input string tag, input logic [15:0] exp);
    logic [3:0] en;
    int idx;
    int first;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = ~{bus.d3, bus.d2, bus.d1, bus.d0};
      case (en)
        4'b0001: idx = 0;
        4'b0010: idx = 1;
        4'b0100: idx = 2;
        4'b1000: idx = 3;
        default: idx = 0;
      endcase
      if (k == 0) first = idx;
      chk({tag, "_onehot"}, 32'($countones(en)), 32'd1);
      chk({tag, "_order"}, 32'(idx), 32'((first + k) % 4));
      chk({tag, "_seg"}, {25'd0, bus.LED_out}, {25'd0, seg(exp[idx*4 +: 4])});
      $display("display %s digit%0d segs=%b expected=%b", tag, idx, bus.LED_out, seg(exp[idx*4 +: 4]));
    end
  endtask

  task automatic pulse_save();
    @(negedge clk);
    bus.SAVE = 1'b1;
    @(negedge clk);
    bus.SAVE = 1'b0;
    @(negedge clk);
  endtask

  task automatic mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    bus.na = a;
    pulse_save();
    bus.na = b;
    pulse_save();
    bus.na = 16'hABCD;
    $display("multiply %s: %h * %h expect %h", tag, a, b, exp);
    check_display(tag, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.SAVE = 1'b0;
    bus.na   = 16'h0005;
    #2;
    chk("rst_d0", {31'd0, bus.d0}, 32'd0);
    chk("rst_d321", {29'd0, bus.d3, bus.d2, bus.d1}, 32'h7);
    chk("rst_led", {25'd0, bus.LED_out}, {25'd0, seg(4'h5)});
    chk("rst_ab", {dut.a_reg, dut.b_reg}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    mult("basic", 16'h4000, 16'h4200, 16'h4600);
    mult("overflow", 16'h5FD1, 16'h5BAD, 16'h7C00);
    mult("inf_zero", 16'h7C00, 16'h0000, 16'h7E00);
    mult("zero", 16'h0000, 16'h4200, 16'h0000);
    mult("underflow", 16'h0400, 16'h0400, 16'h0000);
    mult("negative", 16'hC000, 16'h4200, 16'hC600);

    // Asynchronous reset between clock edges while in SHOW
    bus.na = 16'h0009;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_d0", {31'd0, bus.d0}, 32'd0);
    chk("arst_d321", {29'd0, bus.d3, bus.d2, bus.d1}, 32'h7);
    chk("arst_led", {25'd0, bus.LED_out}, {25'd0, seg(4'h9)});
    chk("arst_ab", {dut.a_reg, dut.b_reg}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Held SAVE in LOAD_A must capture A only once
    bus.na = 16'h3C00;
    @(negedge clk);
    bus.SAVE = 1'b1;
    repeat (5) @(negedge clk);
    bus.SAVE = 1'b0;
    bus.na = 16'h1234;
    check_display("live_entry", 16'h1234);
    chk("held_a", {16'd0, dut.a_reg}, 32'h3C00);
    chk("held_b", {16'd0, dut.b_reg}, 32'h0000);
    bus.na = 16'h4000;
    pulse_save();
    bus.na = 16'hABCD;
    check_display("after_held", 16'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
